// File: rtl/read_arbiter_rr.sv
// Round-robin / fixed-priority read-channel arbiter for a 4-master AXI read mux.
// One read transaction in flight; grant held from issue through the RLAST handshake.
module read_arbiter_rr #(
  parameter int FIXED_PRIO = 0,
  parameter int RR_RESET   = 3
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       m0_axi_arvalid,
  input  logic       m1_axi_arvalid,
  input  logic       m2_axi_arvalid,
  input  logic       m3_axi_arvalid,
  input  logic       s_arvalid,
  input  logic       m_arready,
  input  logic       m_rvalid,
  input  logic       m_rlast,
  input  logic       s_rready,
  output logic       m0_read_accept,
  output logic       m1_read_accept,
  output logic       m2_read_accept,
  output logic       m3_read_accept,
  output logic [1:0] rd_grant_id,
  output logic       rd_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] accept;
  logic [3:0] req;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic       win_valid;

  assign req = {m3_axi_arvalid, m2_axi_arvalid, m1_axi_arvalid, m0_axi_arvalid};

  // The round-robin pointer and rd_grant_id always hold the same value (both
  // load the winner on grant issue only), so one register serves as both.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_idx   = '0;
    scan_idx  = '0;
    win_valid = |req;
    if (FIXED_PRIO != 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (req[i]) win_idx = 2'(i);
      end
    end else begin
      // Descending scan so the nearest requester after the pointer is written last.
      for (int k = 4; k >= 1; k--) begin
        scan_idx = rd_grant_id + 2'(k);
        if (req[scan_idx]) win_idx = scan_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      accept      <= '0;
      rd_grant_id <= 2'(RR_RESET);
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            accept      <= 4'b0001 << win_idx;
            rd_grant_id <= win_idx;
            state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arvalid && m_arready) state <= ST_DATA;
        end
        ST_DATA: begin
          // Returning to idle without regranting guarantees the one-cycle bubble.
          if (m_rvalid && s_rready && m_rlast) begin
            state  <= ST_IDLE;
            accept <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          accept <= '0;
        end
      endcase
    end
  end

  assign {m3_read_accept, m2_read_accept, m1_read_accept, m0_read_accept} = accept;
  assign rd_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_read_arbiter_rr.sv
// Self-checking bench for read_arbiter_rr: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_read_arbiter_rr;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] arv;
  logic       s_arvalid, m_arready, m_rvalid, m_rlast, s_rready;
  logic [3:0] acc_rr, acc_fp;
  logic [1:0] gid_rr, gid_fp;
  logic       busy_rr, busy_fp;

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  read_arbiter_rr #(.FIXED_PRIO(0), .RR_RESET(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_axi_arvalid(arv[0]), .m1_axi_arvalid(arv[1]),
    .m2_axi_arvalid(arv[2]), .m3_axi_arvalid(arv[3]),
    .s_arvalid(s_arvalid), .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .s_rready(s_rready),
    .m0_read_accept(acc_rr[0]), .m1_read_accept(acc_rr[1]),
    .m2_read_accept(acc_rr[2]), .m3_read_accept(acc_rr[3]),
    .rd_grant_id(gid_rr), .rd_busy(busy_rr)
  );

  read_arbiter_rr #(.FIXED_PRIO(1), .RR_RESET(3)) dut_fp (
    .aclk(aclk), .aresetn(aresetn),
    .m0_axi_arvalid(arv[0]), .m1_axi_arvalid(arv[1]),
    .m2_axi_arvalid(arv[2]), .m3_axi_arvalid(arv[3]),
    .s_arvalid(s_arvalid), .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .s_rready(s_rready),
    .m0_read_accept(acc_fp[0]), .m1_read_accept(acc_fp[1]),
    .m2_read_accept(acc_fp[2]), .m3_read_accept(acc_fp[3]),
    .rd_grant_id(gid_fp), .rd_busy(busy_fp)
  );

  typedef struct {
    logic [3:0] arv;
    logic       sav, mar, rv, rl, rr;
    logic [3:0] acc;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] a, input logic sav, input logic mar,
                        input logic rv, input logic rl, input logic rr);
    arv = a; s_arvalid = sav; m_arready = mar; m_rvalid = rv; m_rlast = rl; s_rready = rr;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic reset_pulse();
    set_in(4'b0000, 0, 0, 0, 0, 0);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  // Reference model: per arbiter, transaction phase (0 none, 1 address, 2 data)
  // and the master that holds / last held the grant.
  int         ph[2];
  logic [1:0] lg[2];

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last, input bit fp);
    int idx;
    if (fp) begin
      for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = (int'(last) + k) % 4;
        if (r[idx]) return 2'(idx);
      end
    end
    return last;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      case (ph[m])
        0: if (arv != 4'b0000) begin lg[m] = pick(arv, lg[m], m == 1); ph[m] = 1; end
        1: if (s_arvalid && m_arready) ph[m] = 2;
        default: if (m_rvalid && s_rready && m_rlast) ph[m] = 0;
      endcase
    end
  endtask

  function automatic logic [3:0] model_acc(input int m);
    return (ph[m] != 0) ? (4'b0001 << lg[m]) : 4'b0000;
  endfunction

  initial begin
    // Single request from m2, 4-beat burst with one stall, then idle-state noise
    // and the first rotation step.
    tbl[0]  = '{4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2'd3, 0};
    tbl[1]  = '{4'b0100, 0, 0, 0, 0, 0, 4'b0100, 2'd2, 1};
    tbl[2]  = '{4'b0000, 0, 0, 0, 0, 0, 4'b0100, 2'd2, 1};
    tbl[3]  = '{4'b0000, 1, 1, 0, 0, 0, 4'b0100, 2'd2, 1};
    tbl[4]  = '{4'b0000, 0, 0, 1, 0, 1, 4'b0100, 2'd2, 1};
    tbl[5]  = '{4'b0000, 0, 0, 1, 0, 1, 4'b0100, 2'd2, 1};
    tbl[6]  = '{4'b0000, 0, 0, 1, 0, 0, 4'b0100, 2'd2, 1};
    tbl[7]  = '{4'b0000, 0, 0, 1, 0, 1, 4'b0100, 2'd2, 1};
    tbl[8]  = '{4'b0000, 0, 0, 1, 1, 1, 4'b0000, 2'd2, 0};
    tbl[9]  = '{4'b1111, 1, 1, 1, 1, 1, 4'b1000, 2'd3, 1};
    tbl[10] = '{4'b1111, 1, 1, 0, 0, 0, 4'b1000, 2'd3, 1};
    tbl[11] = '{4'b1111, 0, 0, 1, 1, 1, 4'b0000, 2'd3, 0};
    tbl[12] = '{4'b1111, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 1};

    set_in(4'b0000, 0, 0, 0, 0, 0);
    aresetn = 1'b0;
    tick();
    check("reset_accept", 32'(acc_rr), 32'(4'b0000));
    check("reset_gid", 32'(gid_rr), 32'(2'd3));
    check("reset_busy", 32'(busy_rr), 32'(1'b0));
    aresetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].arv, tbl[i].sav, tbl[i].mar, tbl[i].rv, tbl[i].rl, tbl[i].rr);
      tick();
      check($sformatf("tbl%0d_accept", i), 32'(acc_rr), 32'(tbl[i].acc));
      check($sformatf("tbl%0d_gid", i), 32'(gid_rr), 32'(tbl[i].gid));
      check($sformatf("tbl%0d_busy", i), 32'(busy_rr), 32'(tbl[i].busy));
    end

    // RLAST handshake coincides with m0/m1 requests after a grant to m0.
    set_in(4'b0000, 1, 1, 0, 0, 0); tick();
    check("rlast_req_data", 32'(acc_rr), 32'(4'b0001));
    set_in(4'b0011, 0, 0, 1, 1, 1); tick();
    check("rlast_req_bubble", 32'(acc_rr), 32'(4'b0000));
    check("rlast_req_bubble_busy", 32'(busy_rr), 32'(1'b0));
    set_in(4'b0011, 0, 0, 0, 0, 0); tick();
    check("rlast_req_next", 32'(acc_rr), 32'(4'b0010));
    check("rlast_req_next_gid", 32'(gid_rr), 32'(2'd1));
    set_in(4'b0000, 1, 1, 0, 0, 0); tick();
    set_in(4'b0000, 0, 0, 1, 1, 1); tick();

    // Asynchronous reset in the data phase after a grant to m0.
    set_in(4'b0001, 0, 0, 0, 0, 0); tick();
    check("arst_pre_grant", 32'(acc_rr), 32'(4'b0001));
    set_in(4'b0000, 1, 1, 0, 0, 0); tick();
    set_in(4'b0011, 0, 0, 1, 0, 0);
    aresetn = 1'b0;
    #1;
    check("arst_accept_async", 32'(acc_rr), 32'(4'b0000));
    check("arst_busy_async", 32'(busy_rr), 32'(1'b0));
    check("arst_gid_async", 32'(gid_rr), 32'(2'd3));
    tick();
    aresetn = 1'b1;
    tick();
    check("arst_regrant", 32'(acc_rr), 32'(4'b0001));
    check("arst_regrant_gid", 32'(gid_rr), 32'(2'd0));
    set_in(4'b0000, 1, 1, 0, 0, 0); tick();
    set_in(4'b0000, 0, 0, 1, 1, 1); tick();

    // All four requesting, single-beat reads: rotation 0,1,2,3,0 with one idle cycle.
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      set_in(4'b1111, 0, 0, 0, 0, 0); tick();
      check($sformatf("rot%0d_grant", k), 32'(acc_rr), 32'(4'b0001 << (k % 4)));
      set_in(4'b1111, 1, 1, 0, 0, 0); tick();
      set_in(4'b1111, 0, 0, 1, 1, 1); tick();
      check($sformatf("rot%0d_bubble", k), 32'(acc_rr), 32'(4'b0000));
    end

    // Backpressure on the last beat: grant stable for 5 cycles, idle only after the handshake.
    set_in(4'b0100, 0, 0, 0, 0, 0); tick();
    set_in(4'b0000, 1, 1, 0, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      set_in(4'b0000, 0, 0, 1, 1, 0); tick();
      check($sformatf("bp%0d_accept", k), 32'(acc_rr), 32'(4'b0100));
      check($sformatf("bp%0d_busy", k), 32'(busy_rr), 32'(1'b1));
    end
    set_in(4'b0000, 0, 0, 1, 1, 1); tick();
    check("bp_release", 32'(acc_rr), 32'(4'b0000));
    check("bp_release_busy", 32'(busy_rr), 32'(1'b0));

    // Fixed priority: m1 and m3 requesting continuously, m1 wins every time.
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      set_in(4'b1010, 0, 0, 0, 0, 0); tick();
      check($sformatf("fp%0d_grant", k), 32'(acc_fp), 32'(4'b0010));
      check($sformatf("fp%0d_gid", k), 32'(gid_fp), 32'(2'd1));
      set_in(4'b1010, 1, 1, 0, 0, 0); tick();
      check($sformatf("fp%0d_hold", k), 32'(acc_fp), 32'(4'b0010));
      set_in(4'b1010, 0, 0, 1, 1, 1); tick();
      check($sformatf("fp%0d_bubble", k), 32'(acc_fp), 32'(4'b0000));
    end

    // Randomized traffic against the reference model, both arbitration modes.
    reset_pulse();
    for (int m = 0; m < 2; m++) begin ph[m] = 0; lg[m] = 2'd3; end
    for (int c = 0; c < 1500; c++) begin
      set_in(4'($urandom_range(0, 15)) & {4{($urandom_range(0, 3) == 0)}},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
             1'($urandom_range(0, 9) < 7));
      model_step();
      tick();
      check($sformatf("rnd%0d_rr_accept", c), 32'(acc_rr), 32'(model_acc(0)));
      check($sformatf("rnd%0d_rr_gid", c), 32'(gid_rr), 32'(lg[0]));
      check($sformatf("rnd%0d_rr_busy", c), 32'(busy_rr), 32'(ph[0] != 0));
      check($sformatf("rnd%0d_fp_accept", c), 32'(acc_fp), 32'(model_acc(1)));
      check($sformatf("rnd%0d_fp_gid", c), 32'(gid_fp), 32'(lg[1]));
      check($sformatf("rnd%0d_fp_busy", c), 32'(busy_fp), 32'(ph[1] != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
